// File: rtl/subleq_pkg.sv
// Shared types for the SUBLEQ core: controller states and bus opcodes.
// Imported by subleq_core and by anything that decodes mem_op.
package subleq_pkg;

  typedef enum logic [3:0] {
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_LOAD_A,
    S_LOAD_B,
    S_STORE_B,
    S_RETIRE,
    S_WAIT_STEP,
    S_HALT
  } state_e;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/subleq_core.sv
// SUBLEQ core: mem[B] -= mem[A]; branch to C when result <= 0, else PC+3.
// Ports: clk, reset (sync, low), step_mode/step, mem_* request/handshake bus,
// pc, halted, instr_count (saturating retired count).
module subleq_core
  import subleq_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_mode,
  input  logic                step,
  output logic [1:0]          mem_op,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic [WORD_W/8-1:0] mem_write_bytes,
  input  logic [WORD_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [WORD_W-1:0] a_val_q, a_val_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [1:0]        op_q, op_d;
  logic              c_neg_q, c_neg_d;
  logic              taken_q, taken_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WORD_W-1:0] diff;
  logic [ADDR_W-1:0] pc_next;
  logic              done;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    a_val_d  = a_val_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    c_neg_d  = c_neg_q;
    taken_d  = taken_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    diff     = mem_rdata - a_val_q;
    pc_next  = taken_q ? c_addr_q : pc_q + ADDR_W'(3);
    // ready only counts while a request is actually on the bus
    done     = (op_q != MEM_IDLE) && mem_ready;

    unique case (state_q)
      S_FETCH_A: begin
        // only idle here right after reset; issue the first fetch
        if (op_q == MEM_IDLE) begin
          op_d   = MEM_READ;
          addr_d = pc_q;
        end else if (done) begin
          a_addr_d = mem_rdata[ADDR_W-1:0];
          addr_d   = pc_q + ADDR_W'(1);
          state_d  = S_FETCH_B;
        end
      end
      S_FETCH_B: begin
        if (done) begin
          b_addr_d = mem_rdata[ADDR_W-1:0];
          addr_d   = pc_q + ADDR_W'(2);
          state_d  = S_FETCH_C;
        end
      end
      S_FETCH_C: begin
        if (done) begin
          c_addr_d = mem_rdata[ADDR_W-1:0];
          c_neg_d  = mem_rdata[WORD_W-1];
          addr_d   = a_addr_q;
          state_d  = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (done) begin
          a_val_d = mem_rdata;
          addr_d  = b_addr_q;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (done) begin
          wdata_d = diff;
          taken_d = diff[WORD_W-1] | (diff == '0);
          op_d    = MEM_WRITE;
          addr_d  = b_addr_q;
          state_d = S_STORE_B;
        end
      end
      S_STORE_B: begin
        if (done) begin
          op_d    = MEM_IDLE;
          addr_d  = '0;
          wdata_d = '0;
          state_d = S_RETIRE;
        end
      end
      S_RETIRE: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (taken_q && c_neg_q) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d = pc_next;
          if (step_mode) begin
            state_d = S_WAIT_STEP;
          end else begin
            op_d    = MEM_READ;
            addr_d  = pc_next;
            state_d = S_FETCH_A;
          end
        end
      end
      S_WAIT_STEP: begin
        if (step) begin
          op_d    = MEM_READ;
          addr_d  = pc_q;
          state_d = S_FETCH_A;
        end
      end
      S_HALT: begin
      end
      default: state_d = S_FETCH_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH_A;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      a_val_q  <= '0;
      wdata_q  <= '0;
      op_q     <= MEM_IDLE;
      c_neg_q  <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      a_val_q  <= a_val_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      c_neg_q  <= c_neg_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_op          = op_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_write_bytes = {(WORD_W/8){op_q == MEM_WRITE}};
  assign pc              = pc_q;
  assign halted          = halted_q;
  assign instr_count     = cnt_q;

endmodule

// File: tb/tb_subleq_core.sv
// Bench for subleq_core: RAM model with 0..3 wait cycles, directed programs,
// step mode, mid-access reset, random programs vs. an interpreter, 16/8 wrap.
module tb_subleq_core;

  localparam int WW = 64;
  localparam int AW = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic reset, step_mode, step;
  logic [1:0] mem_op;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [WW/8-1:0] mem_write_bytes;
  logic [WW-1:0] mem_rdata;
  logic mem_ready;
  logic [AW-1:0] pc;
  logic halted;
  logic [CW-1:0] instr_count;

  logic reset2;
  logic [1:0] op2;
  logic [7:0] addr2;
  logic [15:0] wdata2;
  logic [1:0] wb2;
  logic [15:0] rdata2;
  logic ready2;
  logic [7:0] pc2;
  logic halted2;
  logic [7:0] cnt2;

  always #5 clk = ~clk;

  subleq_core #(.WORD_W(WW), .ADDR_W(AW), .RESET_PC(16'h0000), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .step_mode(step_mode), .step(step),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write_bytes(mem_write_bytes), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .halted(halted),
    .instr_count(instr_count)
  );

  subleq_core #(.WORD_W(16), .ADDR_W(8), .RESET_PC(8'hFE), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset2), .step_mode(1'b0), .step(1'b0),
    .mem_op(op2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_write_bytes(wb2), .mem_rdata(rdata2),
    .mem_ready(ready2), .pc(pc2), .halted(halted2),
    .instr_count(cnt2)
  );

  // main RAM: img is the load image, mem is the live array
  logic [WW-1:0] img [0:65535];
  logic [WW-1:0] mem [0:65535];
  logic [WW-1:0] ref_mem [0:65535];
  logic load_req;
  int wcnt, wait_cfg, wait_sel;
  bit rand_wait, spurious;

  assign mem_ready = ((mem_op != 2'b00) && (wcnt == wait_cfg)) || spurious;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 65536; i++) mem[i] = img[i];
    end
    if (mem_op == 2'b00) begin
      wcnt <= 0;
      if (!rand_wait) wait_cfg <= wait_sel;
    end else if (wcnt == wait_cfg) begin
      if (mem_op == 2'b10) mem[mem_addr] = mem_wdata;
      wcnt <= 0;
      if (rand_wait) wait_cfg <= int'($urandom_range(0, 3));
      else wait_cfg <= wait_sel;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  logic [15:0] img2 [0:255];
  logic [15:0] mem2 [0:255];
  logic load2;
  assign ready2 = 1'b1;
  assign rdata2 = mem2[addr2];

  always @(posedge clk) begin
    if (load2) begin
      for (int i = 0; i < 256; i++) mem2[i] = img2[i];
    end else if (op2 == 2'b10) begin
      mem2[addr2] = wdata2;
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  bit mon_en;
  bit prev_pend;
  logic [1:0] prev_op;
  logic [AW-1:0] prev_addr;
  logic [15:0] mpc;
  bit mhalt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle; bus must hold while a request waits for ready
  task automatic tick();
    @(negedge clk);
    if (mon_en && prev_pend) begin
      chk("hold_op", mem_op, prev_op);
      chk("hold_addr", mem_addr, prev_addr);
    end
    if (mon_en && mem_op == 2'b10) chk("wbytes", mem_write_bytes, 8'hFF);
    prev_pend = (mem_op != 2'b00) && !mem_ready;
    prev_op   = mem_op;
    prev_addr = mem_addr;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    repeat (n - 1) @(negedge clk);
    reset = 1'b1;
    prev_pend = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 65536; i++) img[i] = '0;
  endtask

  task automatic wait_retire(input int budget, output int n);
    logic [CW-1:0] start;
    start = instr_count;
    n = 0;
    while (instr_count == start && n < budget) begin
      tick();
      n++;
    end
    chk("retire_seen", 64'(instr_count != start), 64'd1);
  endtask

  task automatic model_step(output logic [15:0] bi);
    logic [63:0] a, b, c, d;
    logic [15:0] p1, p2, ai;
    p1 = mpc + 16'd1;
    p2 = mpc + 16'd2;
    a = ref_mem[mpc];
    b = ref_mem[p1];
    c = ref_mem[p2];
    ai = a[15:0];
    bi = b[15:0];
    d = ref_mem[bi] - ref_mem[ai];
    ref_mem[bi] = d;
    if (d[63] || d == 64'd0) begin
      if (c[63]) mhalt = 1'b1;
      else mpc = c[15:0];
    end else begin
      mpc = mpc + 16'd3;
    end
  endtask

  task automatic load_prog1();
    clear_img();
    img[0] = 64'd3; img[1] = 64'd4; img[2] = 64'd6;
    img[3] = 64'd5; img[4] = 64'd7; img[5] = 64'd6;
    img[6] = 64'd9; img[7] = 64'd9; img[8] = '1;
    img[9] = 64'd42;
  endtask

  task automatic run_prog1(input int w);
    int n;
    wait_sel = w;
    load_prog1();
    do_reset(2);
    wait_retire(200, n);
    chk($sformatf("p1_lat1_w%0d", w), 64'(n), 64'(6 * w + 8));
    chk("p1_mem4", mem[4], 64'd2);
    chk("p1_pc1", pc, 64'd3);
    chk("p1_cnt1", instr_count, 64'd1);
    wait_retire(200, n);
    chk($sformatf("p1_lat2_w%0d", w), 64'(n), 64'(6 * w + 7));
    chk("p1_mem2", mem[2], 64'd0);
    chk("p1_pc2", pc, 64'd6);
    wait_retire(200, n);
    chk("p1_halt", halted, 64'd1);
    chk("p1_pc3", pc, 64'd6);
    chk("p1_mem9", mem[9], 64'd0);
    repeat (12) tick();
    chk("p1_cnt_hold", instr_count, 64'd3);
    chk("p1_op_idle", mem_op, 64'd0);
  endtask

  task automatic run_prog2(input int w);
    int n;
    wait_sel = w;
    clear_img();
    img[0] = 64'd3; img[1] = 64'd3; img[2] = '1;
    img[3] = 64'h1234;
    do_reset(2);
    wait_retire(200, n);
    chk("p2_mem3", mem[3], 64'd0);
    chk("p2_halt", halted, 64'd1);
    chk("p2_pc", pc, 64'd0);
    repeat (20) tick();
    chk("p2_cnt", instr_count, 64'd1);
    chk("p2_op", mem_op, 64'd0);
    chk("p2_pc_hold", pc, 64'd0);
  endtask

  initial begin
    int n;
    bit found;
    logic [15:0] bi;
    reset = 1'b0; step_mode = 1'b0; step = 1'b0;
    spurious = 1'b0; rand_wait = 1'b0; wait_sel = 0;
    load_req = 1'b0; mon_en = 1'b1; prev_pend = 1'b0;
    reset2 = 1'b0; load2 = 1'b0;

    load_prog1();
    do_reset(3);
    chk("rst_pc", pc, 64'd0);
    chk("rst_op", mem_op, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_wbytes", mem_write_bytes, 64'd0);
    chk("rst_halted", halted, 64'd0);
    chk("rst_cnt", instr_count, 64'd0);

    run_prog1(0);
    run_prog1(3);
    run_prog2(0);
    run_prog2(3);

    // single-step
    step_mode = 1'b1;
    wait_sel = 1;
    load_prog1();
    do_reset(2);
    wait_retire(200, n);
    repeat (8) tick();
    chk("st_park_cnt", instr_count, 64'd1);
    chk("st_park_op", mem_op, 64'd0);
    spurious = 1'b1;
    repeat (3) tick();
    spurious = 1'b0;
    tick();
    chk("st_spur_cnt", instr_count, 64'd1);
    chk("st_spur_op", mem_op, 64'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_retire(200, n);
    chk("st_cnt2", instr_count, 64'd2);
    chk("st_mem2", mem[2], 64'd0);
    repeat (10) tick();
    chk("st_park2", instr_count, 64'd2);
    step_mode = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_retire(200, n);
    chk("st_halt", halted, 64'd1);
    chk("st_cnt3", instr_count, 64'd3);

    // reset while STORE_B is waiting
    wait_sel = 3;
    load_prog1();
    do_reset(2);
    mon_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (mem_op == 2'b10) found = 1'b1;
    end
    chk("mr_found_write", 64'(found), 64'd1);
    reset = 1'b0;
    repeat (2) tick();
    chk("mr_op", mem_op, 64'd0);
    chk("mr_pc", pc, 64'd0);
    chk("mr_cnt", instr_count, 64'd0);
    chk("mr_nowrite", mem[4], 64'd7);
    reset = 1'b1;
    prev_pend = 1'b0;
    mon_en = 1'b1;
    wait_retire(200, n);
    chk("mr_mem4", mem[4], 64'd2);
    chk("mr_pc1", pc, 64'd3);
    chk("mr_cnt1", instr_count, 64'd1);

    // random programs vs. interpreter
    rand_wait = 1'b1;
    for (int r = 0; r < 4; r++) begin
      clear_img();
      for (int i = 0; i < 256; i++) begin
        img[i] = 64'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0)
          img[i] = -64'($urandom_range(1, 4));
      end
      for (int i = 0; i < 65536; i++) ref_mem[i] = img[i];
      mpc = 16'd0;
      mhalt = 1'b0;
      do_reset(2);
      for (int k = 1; k <= 40 && !mhalt; k++) begin
        model_step(bi);
        wait_retire(200, n);
        chk($sformatf("rnd%0d_pc_%0d", r, k), pc, mpc);
        chk($sformatf("rnd%0d_cnt_%0d", r, k), instr_count, 64'(k));
        chk($sformatf("rnd%0d_memb_%0d", r, k), mem[bi], ref_mem[bi]);
        chk($sformatf("rnd%0d_halt_%0d", r, k), halted, 64'(mhalt));
      end
    end
    rand_wait = 1'b0;

    // 16-bit word / 8-bit address build: pc FE+3 wraps to 01
    for (int i = 0; i < 256; i++) img2[i] = '0;
    img2[8'hFE] = 16'h0010; img2[8'hFF] = 16'h0011; img2[0] = 16'h0020;
    img2[8'h10] = 16'd1; img2[8'h11] = 16'd5;
    img2[1] = 16'h0012; img2[2] = 16'h0012; img2[3] = 16'h8000;
    img2[8'h12] = 16'd7;
    @(negedge clk);
    reset2 = 1'b0;
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    @(negedge clk);
    chk("w_rst_pc", pc2, 64'hFE);
    reset2 = 1'b1;
    n = 0;
    while (cnt2 == 8'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w_cnt1", cnt2, 64'd1);
    chk("w_pc_wrap", pc2, 64'h01);
    chk("w_mem11", mem2[8'h11], 64'd4);
    n = 0;
    while (!halted2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w_halt", halted2, 64'd1);
    chk("w_pc_halt", pc2, 64'h01);
    chk("w_cnt2", cnt2, 64'd2);
    chk("w_mem12", mem2[8'h12], 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
